// File: rtl/qspi_slave.sv
// qspi_slave: clk-oversampled mode-0 SPI/QSPI target turning bus traffic into byte register writes and reads.
// Ports: clk, rst_n (async, active-low); qspi_type data width, latched at csn fall;
//   qspi_sck/qspi_csn/qspi_dq*_i bus inputs (async to clk); qspi_dq*_o/qspi_dq*_en bus outputs;
//   wr_vld/wr_addr/wr_dat write pulse; rd_req_vld/rd_req_addr and rd_rsp_vld/rd_rsp_dat read handshake;
//   busy while csn is low; err pulses on read underrun.
// Define QSPI_SLAVE_QUAD_EN for quad width; without it 2'b10 runs as single and dq2/dq3 stay undriven.
module qspi_slave #(
  parameter int DUMMY_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] qspi_type,
  input  logic       qspi_sck,
  input  logic       qspi_csn,
  input  logic       qspi_dq0_i,
  input  logic       qspi_dq1_i,
  input  logic       qspi_dq2_i,
  input  logic       qspi_dq3_i,
  output logic       qspi_dq0_o,
  output logic       qspi_dq1_o,
  output logic       qspi_dq2_o,
  output logic       qspi_dq3_o,
  output logic       qspi_dq0_en,
  output logic       qspi_dq1_en,
  output logic       qspi_dq2_en,
  output logic       qspi_dq3_en,
  output logic       wr_vld,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_dat,
  output logic       rd_req_vld,
  output logic [2:0] rd_req_addr,
  input  logic       rd_rsp_vld,
  input  logic [7:0] rd_rsp_dat,
  output logic       busy,
  output logic       err
);
`ifdef QSPI_SLAVE_QUAD_EN
  localparam logic QUAD = 1'b1;
`else
  localparam logic QUAD = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CMD, DUMMY, WDATA, RDATA} state_t;
  state_t state, state_nx;
  logic [2:0] sck_s, csn_s, addr, ocnt, ocnt_ld;
  logic [3:0] dq_m, dq_s, dq_o, dq_en, step, drv, drv_en, cnt;
  logic [1:0] wid;
  logic [7:0] sh, sh_in, cmd_byte, osh, src, buf_dat;
  logic buf_vld, pend, dual, quad, sck_rise, sck_fall, csn_rise, csn_fall;
  logic cmd_done, dly_done, wr_done, load;
  // bit [2] of each sync chain is the previous synchronized value, used for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_s <= '0;
      csn_s <= '1;
      dq_m  <= '0;
      dq_s  <= '0;
    end else begin
      sck_s <= {sck_s[1:0], qspi_sck};
      csn_s <= {csn_s[1:0], qspi_csn};
      dq_m  <= {qspi_dq3_i, qspi_dq2_i, qspi_dq1_i, qspi_dq0_i};
      dq_s  <= dq_m;
    end
  always_comb begin
    sck_rise = sck_s[1] & ~sck_s[2];
    sck_fall = ~sck_s[1] & sck_s[2];
    csn_rise = csn_s[1] & ~csn_s[2];
    csn_fall = ~csn_s[1] & csn_s[2];
    dual     = wid == 2'b01;
    quad     = QUAD & (wid == 2'b10);
    step     = quad ? 4'd4 : dual ? 4'd2 : 4'd1;
    ocnt_ld  = quad ? 3'd1 : dual ? 3'd3 : 3'd7;
    cmd_byte = {sh[6:0], dq_s[0]};
    sh_in    = quad ? {sh[3:0], dq_s} : dual ? {sh[5:0], dq_s[1:0]} : cmd_byte;
    cmd_done = state == CMD && sck_rise && cnt == 4'd7;
    dly_done = state == DUMMY && sck_rise && cnt == 4'(DUMMY_CYC - 1);
    wr_done  = state == WDATA && sck_rise && cnt + step == 4'd8;
    // a new byte enters the shifter on the first falling edge of each byte slot
    load     = state == RDATA && sck_fall && ocnt == 3'd0;
    src      = load ? (buf_vld ? buf_dat : 8'hFF) : osh;
    drv      = quad ? src[7:4] : dual ? {2'b00, src[7:6]} : {2'b00, src[7], 1'b0};
    drv_en   = quad ? 4'b1111 : dual ? 4'b0011 : 4'b0010;
    state_nx = state;
    if (cmd_done) state_nx = !cmd_byte[7] ? WDATA : (DUMMY_CYC == 0) ? RDATA : DUMMY;
    if (dly_done) state_nx = RDATA;
    if (csn_fall) state_nx = CMD;
    if (csn_rise) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= '0;
      wid         <= '0;
      sh          <= '0;
      addr        <= '0;
      osh         <= '0;
      ocnt        <= '0;
      buf_vld     <= 1'b0;
      buf_dat     <= '0;
      pend        <= 1'b0;
      dq_o        <= '0;
      dq_en       <= '0;
      wr_vld      <= 1'b0;
      wr_addr     <= '0;
      wr_dat      <= '0;
      rd_req_vld  <= 1'b0;
      rd_req_addr <= '0;
      err         <= 1'b0;
    end else begin
      wr_vld     <= 1'b0;
      rd_req_vld <= 1'b0;
      err        <= 1'b0;
      if (csn_fall) begin
        cnt     <= '0;
        wid     <= qspi_type;
        ocnt    <= '0;
        buf_vld <= 1'b0;
        pend    <= 1'b0;
      end
      if (state == CMD && sck_rise) begin
        sh  <= cmd_byte;
        cnt <= cmd_done ? 4'd0 : cnt + 4'd1;
        if (cmd_done) addr <= cmd_byte[2:0];
        if (cmd_done && cmd_byte[7]) begin
          rd_req_vld  <= 1'b1;
          rd_req_addr <= cmd_byte[2:0];
          pend        <= 1'b1;
        end
      end
      if (state == DUMMY && sck_rise) cnt <= cnt + 4'd1;
      if (state == WDATA && sck_rise) begin
        sh  <= sh_in;
        cnt <= wr_done ? 4'd0 : cnt + step;
        if (wr_done) begin
          wr_vld  <= 1'b1;
          wr_addr <= addr;
          wr_dat  <= sh_in;
          addr    <= addr + 3'd1;
        end
      end
      if (state == RDATA && sck_fall) begin
        osh   <= src << step;
        ocnt  <= load ? ocnt_ld : ocnt - 3'd1;
        dq_o  <= drv;
        dq_en <= drv_en;
        if (load) begin
          err         <= ~buf_vld;
          buf_vld     <= 1'b0;
          rd_req_vld  <= 1'b1;
          rd_req_addr <= rd_req_addr + 3'd1;
          pend        <= 1'b1;
        end
      end
      // a response colliding with a load is dropped; the new request stays outstanding
      if (pend && rd_rsp_vld && !load) begin
        buf_vld <= 1'b1;
        buf_dat <= rd_rsp_dat;
        pend    <= 1'b0;
      end
      if (csn_rise) begin
        dq_o  <= '0;
        dq_en <= '0;
      end
    end
  assign busy        = ~csn_s[1];
  assign qspi_dq0_o  = dq_o[0];
  assign qspi_dq1_o  = dq_o[1];
  assign qspi_dq2_o  = QUAD & dq_o[2];
  assign qspi_dq3_o  = QUAD & dq_o[3];
  assign qspi_dq0_en = dq_en[0];
  assign qspi_dq1_en = dq_en[1];
  assign qspi_dq2_en = QUAD & dq_en[2];
  assign qspi_dq3_en = QUAD & dq_en[3];
endmodule
